// File: rtl/noise_pkg.sv
// Shared definitions for the noise pixel classifier: mode encodings and frame FSM states.
package noise_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SALT = 2'b01,
        MODE_PEP  = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_e;

    // True when the mode enables salt (bright) detection.
    function automatic logic mode_has_salt(input mode_e m);
        return (m == MODE_SALT) || (m == MODE_BOTH);
    endfunction

    // True when the mode enables pepper (dark) detection.
    function automatic logic mode_has_pep(input mode_e m);
        return (m == MODE_PEP) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/noise_pixel_classifier_if.sv
// Pixel stream bus: input beat channel (s_*) and classified output channel (m_*).
interface noise_pixel_classifier_if #(
    parameter int PIX_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_pix;
    logic             s_sof;
    logic             s_eof;

    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_pix;
    logic             m_salt;
    logic             m_pep;
    logic             m_sof;
    logic             m_eof;

    // Classifier side of the bus.
    modport slave (
        input  s_valid, s_pix, s_sof, s_eof, m_ready,
        output s_ready, m_valid, m_pix, m_salt, m_pep, m_sof, m_eof
    );

    // Environment side: produces input beats, consumes classified beats.
    modport master (
        output s_valid, s_pix, s_sof, s_eof, m_ready,
        input  s_ready, m_valid, m_pix, m_salt, m_pep, m_sof, m_eof
    );
endinterface

// File: rtl/noise_sat_counter.sv
// Saturating event counter: load a single flag bit, or add the flag, never wrapping.
module noise_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_bit,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_next
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;

    // Next value: restart from this beat's flag, or add the flag unless already at full scale.
    always_comb begin
        w_next = r_cnt;
        if (i_load) begin
            w_next    = '0;
            w_next[0] = i_bit;
        end else if (i_bit && (r_cnt != '1)) begin
            w_next = r_cnt + 1'b1;
        end
    end

    // Counter register, updated only on counted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_next = w_next;
endmodule

// File: rtl/noise_pixel_classifier.sv
// Salt/pepper pixel classifier: two-stage valid pipeline plus per-frame noise statistics.
module noise_pixel_classifier
    import noise_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [PIX_W-1:0]         salt_thr,
    input  logic [PIX_W-1:0]         pep_thr,
    noise_pixel_classifier_if.slave  bus,
    output logic                     stat_valid,
    output logic [CNT_W-1:0]         stat_salt,
    output logic [CNT_W-1:0]         stat_pep
);
    mode_e            w_mode;
    logic             w_salt_hit;
    logic             w_pep_hit;
    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_salt_cnt;
    logic [CNT_W-1:0] w_pep_cnt;
    logic [CNT_W-1:0] w_salt_next;
    logic [CNT_W-1:0] w_pep_next;

    logic             r_s1_valid;
    logic [PIX_W-1:0] r_s1_pix;
    logic             r_s1_salt;
    logic             r_s1_pep;
    logic             r_s1_sof;
    logic             r_s1_eof;

    logic             r_s2_valid;
    logic [PIX_W-1:0] r_s2_pix;
    logic             r_s2_salt;
    logic             r_s2_pep;
    logic             r_s2_sof;
    logic             r_s2_eof;

    frame_state_e     r_state;
    logic             r_stat_valid;
    logic [CNT_W-1:0] r_stat_salt;
    logic [CNT_W-1:0] r_stat_pep;

    assign w_mode     = mode_e'(mode);
    // Salt has priority when thresholds overlap.
    assign w_salt_hit = mode_has_salt(w_mode) && (bus.s_pix >= salt_thr);
    assign w_pep_hit  = mode_has_pep(w_mode) && (bus.s_pix <= pep_thr) && !w_salt_hit;

    // Ready chain depends only on stage occupancy and m_ready, never on s_valid.
    assign w_s2_load  = !r_s2_valid || bus.m_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign bus.s_ready = rst_n && w_s1_load;
    assign w_in_xfer  = bus.s_valid && bus.s_ready;
    assign w_out_xfer = r_s2_valid && bus.m_ready;

    // Stage 1: capture the input beat together with its classification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_salt  <= 1'b0;
            r_s1_pep   <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_s1_pix  <= bus.s_pix;
                r_s1_salt <= w_salt_hit;
                r_s1_pep  <= w_pep_hit;
                r_s1_sof  <= bus.s_sof;
                r_s1_eof  <= bus.s_eof;
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_pix   <= '0;
            r_s2_salt  <= 1'b0;
            r_s2_pep   <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eof   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_pix  <= r_s1_pix;
                r_s2_salt <= r_s1_salt;
                r_s2_pep  <= r_s1_pep;
                r_s2_sof  <= r_s1_sof;
                r_s2_eof  <= r_s1_eof;
            end
        end
    end

    assign bus.m_valid = r_s2_valid;
    assign bus.m_pix   = r_s2_pix;
    assign bus.m_salt  = r_s2_salt;
    assign bus.m_pep   = r_s2_pep;
    assign bus.m_sof   = r_s2_sof;
    assign bus.m_eof   = r_s2_eof;

    // A beat is counted when it opens a frame or arrives inside one; sof always restarts counting.
    assign w_cnt_en = w_out_xfer && (r_s2_sof || (r_state == ST_IN_FRAME));

    noise_sat_counter #(.CNT_W(CNT_W)) u_salt_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_cnt_en),
        .i_load (r_s2_sof),
        .i_bit  (r_s2_salt),
        .o_cnt  (w_salt_cnt),
        .o_next (w_salt_next)
    );

    noise_sat_counter #(.CNT_W(CNT_W)) u_pep_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_cnt_en),
        .i_load (r_s2_sof),
        .i_bit  (r_s2_pep),
        .o_cnt  (w_pep_cnt),
        .o_next (w_pep_next)
    );

    // Frame FSM: tracks frame boundaries on output transfers and latches totals at eof.
    // Totals come from the counters' next value so the eof beat itself is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_stat_valid <= 1'b0;
            r_stat_salt  <= '0;
            r_stat_pep   <= '0;
        end else begin
            r_stat_valid <= 1'b0;
            if (w_cnt_en) begin
                if (r_s2_eof) begin
                    r_stat_salt  <= w_salt_next;
                    r_stat_pep   <= w_pep_next;
                    r_stat_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                end else begin
                    r_state      <= ST_IN_FRAME;
                end
            end
        end
    end

    assign stat_valid = r_stat_valid;
    assign stat_salt  = r_stat_salt;
    assign stat_pep   = r_stat_pep;

    // Running counts are only observed through their next value at eof.
    logic w_unused;
    assign w_unused = ^{w_salt_cnt, w_pep_cnt};
endmodule

// File: doc/noise_pixel_classifier.md
NOISE_PIXEL_CLASSIFIER -- requirements
Module: noise_pixel_classifier

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter CNT_W, default 16, per-frame statistic counter width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mode  in  2  classify enable: 00 off, 01 salt only, 10 pepper only, 11 both.
REQ-006 salt_thr  in  PIX_W  pixel >= salt_thr is salt candidate.
REQ-007 pep_thr  in  PIX_W  pixel <= pep_thr is pepper candidate.
REQ-008 s_valid / s_ready  in / out  1  input handshake; beat transfers when both high.
REQ-009 s_pix  in  PIX_W  input pixel; s_sof, s_eof  in  1  frame start/end markers on the beat.
REQ-010 m_valid / m_ready  out / in  1  output handshake.
REQ-011 m_pix  out  PIX_W  pixel passed unchanged; m_salt, m_pep, m_sof, m_eof  out  1  per-beat flags.
REQ-012 stat_valid  out  1  one-cycle pulse, frame statistics valid.
REQ-013 stat_salt, stat_pep  out  CNT_W  salt/pepper counts of last completed frame.

Function
REQ-014 Datapath SHALL be a two-stage valid pipeline: S1 registers beat plus classification, S2 is output register.
REQ-015 Latency SHALL be exactly 2 cycles from input transfer to m_valid with m_ready held high; throughput one beat/cycle.
REQ-016 A stage SHALL load when empty or when its downstream stage moves in the same cycle; s_ready SHALL equal that condition for S1, with no combinational path from s_valid to s_ready.
REQ-017 m_valid SHALL stay high and m_pix/flags SHALL hold stable until m_ready is seen high.
REQ-018 Salt flag = mode[0] and (s_pix >= salt_thr); pepper flag = mode[1] and (s_pix <= pep_thr); mode and thresholds SHALL be sampled at input transfer.
REQ-019 When both conditions are true (overlapping thresholds), salt SHALL win and pepper SHALL be 0.
REQ-020 Frame FSM with states IDLE and IN_FRAME, advanced only on output transfers (m_valid and m_ready).
REQ-021 IDLE: beat without sof passes through, not counted; beat with sof enters IN_FRAME, counters load this beat's flags (0 or 1).
REQ-022 IN_FRAME: beat increments salt/pepper counters per its flags; sof mid-frame SHALL restart counters from that beat with no stat_valid pulse.
REQ-023 eof beat in IN_FRAME (or sof+eof same beat from either state) SHALL be counted, totals latched into stat_salt/stat_pep, stat_valid pulsed the following cycle, FSM to IDLE.
REQ-024 eof in IDLE without sof SHALL be ignored for statistics.
REQ-025 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-026 stat_salt/stat_pep SHALL hold their value until the next frame completes.

Reset
REQ-027 On rst_n low: S1/S2 valid 0, m_valid 0, m_pix and all flags 0, stat_valid 0, stat_salt/stat_pep 0, counters 0, FSM IDLE.
REQ-028 Reset mid-frame SHALL discard in-flight beats and partial counts; no stat_valid after release until a full sof..eof frame completes.
REQ-029 s_ready SHALL be 0 while rst_n is low and 1 on first cycle after release.

Structure
REQ-030 Shared package noise_pkg SHALL hold mode encodings (MODE_OFF, MODE_SALT, MODE_PEP, MODE_BOTH) and the frame FSM state type.
REQ-031 One sub-module noise_sat_counter (parameter CNT_W; clear-load, increment, saturate) SHALL be instantiated twice (salt, pepper).

Verification
REQ-032 mode=11, salt_thr=250, pep_thr=5, frame sof..eof of 8 pixels {255,0,128,251,5,6,249,250}, m_ready=1 -> flags salt at 0,3,7; pepper at 1,4; stat_salt=3, stat_pep=2, stat_valid one pulse.
REQ-033 Same frame with m_ready toggling 1/0 every cycle -> identical output order/flags, no beat dropped or duplicated, m_pix stable while stalled.
REQ-034 CNT_W=3, 10-pixel all-255 frame, mode=01 -> stat_salt=7 (saturated), stat_pep=0.
REQ-035 salt_thr=100, pep_thr=200, pixel 150, mode=11 -> m_salt=1, m_pep=0; mode=00 -> both 0.
REQ-036 sof at pixel 3, sof again at pixel 6, eof at pixel 9 -> one stat_valid pulse, counts only pixels 6..9; single beat with sof+eof=255 -> stat_salt=1.
REQ-037 rst_n low mid-frame for 2 cycles -> m_valid=0 and stats 0 immediately; next complete frame reports correct counts.
